// File: rtl/mipsfpga_ahb_lcd_ctrl_pkg.sv
// Shared definitions for the LCD command sequencer: FSM states and queue entry layout.
package mipsfpga_ahb_lcd_ctrl_pkg;

    // Sequencer states: pop an entry, pulse the SPI engine, wait for it, then settle.
    typedef enum logic [2:0] {
        LCD_S_IDLE = 3'd0,
        LCD_S_SEND = 3'd1,
        LCD_S_ARM  = 3'd2,
        LCD_S_WAIT = 3'd3,
        LCD_S_GAP  = 3'd4
    } lcd_state_t;

    // Queue entry layout: {long, rs, data[7:0]}
    localparam int LCD_ENTRY_W = 10;
    localparam int LCD_F_LONG  = 9;
    localparam int LCD_F_RS    = 8;

    // Larger of two integers, used to size the settle counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mipsfpga_ahb_lcd_fifo.sv
// Synchronous FIFO holding queued LCD entries; flush empties it on the next edge.
module mipsfpga_ahb_lcd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push & ~flush & (~full | pop_ok);
    assign pop_ok  = pop & ~empty & ~flush;
    assign full    = (level == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr];

    // Storage array; no reset needed because reads are only consumed when non-empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); the level tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                level <= level + 1'b1;
            end else if (!push_ok && pop_ok) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mipsfpga_ahb_lcd_ctrl.sv
// LCD command sequencer: queues CPU-written entries and feeds them to the SPI engine one by one.
module mipsfpga_ahb_lcd_ctrl
    import mipsfpga_ahb_lcd_ctrl_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int GAP_CYCLES  = 50,
    parameter int LONG_CYCLES = 100000
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    wr_en,
    input  logic [LCD_ENTRY_W-1:0]  wr_data,
    input  logic                    flush,
    input  logic                    clr_ovf,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    fifo_full,
    output logic                    fifo_empty,
    output logic                    busy,
    output logic                    overflow,
    output logic [7:0]              spi_data,
    output logic                    spi_rs,
    output logic                    spi_send,
    input  logic                    spi_done
);

    localparam int CNT_MAX = max_int(max_int(LONG_CYCLES, GAP_CYCLES), 1);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LONG_LOAD = (LONG_CYCLES > 0) ? CNT_W'(LONG_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0)  ? CNT_W'(GAP_CYCLES - 1)  : '0;

    lcd_state_t             state;
    lcd_state_t             state_next;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic                   long_q;
    logic                   pop;
    logic                   ovf_set;
    logic [LCD_ENTRY_W-1:0] head;

    mipsfpga_ahb_lcd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LCD_ENTRY_W)
    ) u_fifo (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .push    (wr_en),
        .pop     (pop),
        .flush   (flush),
        .wr_data (wr_data),
        .rd_data (head),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A push into a full FIFO is dropped unless the head leaves in the same cycle.
    assign ovf_set = wr_en & ~flush & fifo_full & ~pop;
    assign busy    = (state != LCD_S_IDLE) | ~fifo_empty;

    // Next-state logic: pop, pulse send, skip the engine latency cycle, wait for done, settle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pop        = 1'b0;
        spi_send   = 1'b0;
        case (state)
            LCD_S_IDLE: begin
                if (!fifo_empty && !flush) begin
                    pop        = 1'b1;
                    state_next = LCD_S_SEND;
                end
            end
            LCD_S_SEND: begin
                spi_send   = 1'b1;
                state_next = LCD_S_ARM;
            end
            LCD_S_ARM: begin
                state_next = LCD_S_WAIT;
            end
            LCD_S_WAIT: begin
                if (spi_done) begin
                    if (long_q && (LONG_CYCLES > 0)) begin
                        cnt_next   = LONG_LOAD;
                        state_next = LCD_S_GAP;
                    end else if (!long_q && (GAP_CYCLES > 0)) begin
                        cnt_next   = GAP_LOAD;
                        state_next = LCD_S_GAP;
                    end else begin
                        state_next = LCD_S_IDLE;
                    end
                end
            end
            LCD_S_GAP: begin
                if (cnt == '0) begin
                    state_next = LCD_S_IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = LCD_S_IDLE;
            end
        endcase
    end

    // State, settle counter and the latched byte that stays on the SPI bus until the next pop.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= LCD_S_IDLE;
            cnt      <= '0;
            long_q   <= 1'b0;
            spi_data <= 8'h00;
            spi_rs   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (pop) begin
                long_q   <= head[LCD_F_LONG];
                spi_rs   <= head[LCD_F_RS];
                spi_data <= head[7:0];
            end
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mipsfpga_ahb_lcd_ctrl.sv
// Self-checking bench for the LCD sequencer against a queue/timestamp reference model.
module tb_mipsfpga_ahb_lcd_ctrl;

    localparam int DEPTH = 8;
    localparam int GAP   = 50;
    localparam int LONG  = 20;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             HCLK     = 1'b0;
    logic             HRESETn  = 1'b0;
    logic             wr_en    = 1'b0;
    logic [9:0]       wr_data  = '0;
    logic             flush    = 1'b0;
    logic             clr_ovf  = 1'b0;
    logic             spi_done = 1'b1;
    logic [LVL_W-1:0] fifo_level;
    logic             fifo_full;
    logic             fifo_empty;
    logic             busy;
    logic             overflow;
    logic [7:0]       spi_data;
    logic             spi_rs;
    logic             spi_send;

    int checks = 0;
    int errors = 0;

    // Reference model: entry queue, sticky flag, last issued entry and transfer timestamps.
    logic [9:0] mq[$];
    logic       m_ovf;
    logic [9:0] m_cur;
    int         cyc;
    int         pop_cyc;
    int         done_cyc;

    mipsfpga_ahb_lcd_ctrl #(
        .DEPTH       (DEPTH),
        .GAP_CYCLES  (GAP),
        .LONG_CYCLES (LONG)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .flush      (flush),
        .clr_ovf    (clr_ovf),
        .fifo_level (fifo_level),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .busy       (busy),
        .overflow   (overflow),
        .spi_data   (spi_data),
        .spi_rs     (spi_rs),
        .spi_send   (spi_send),
        .spi_done   (spi_done)
    );

    always #5 HCLK = ~HCLK;

    task automatic check_output(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    function int settle_of(input logic [9:0] e);
        return e[9] ? LONG : GAP;
    endfunction

    // The sequencer is free once the settle period after the observed done has elapsed.
    function bit model_idle();
        return (pop_cyc < 0) || (done_cyc >= 0 && cyc >= done_cyc + 1 + settle_of(m_cur));
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf    = 1'b0;
        m_cur    = '0;
        pop_cyc  = -1;
        done_cyc = -1;
    endtask

    task automatic check_all();
        check_output("level",    int'(fifo_level), mq.size());
        check_output("full",     int'(fifo_full),  int'(mq.size() == DEPTH));
        check_output("empty",    int'(fifo_empty), int'(mq.size() == 0));
        check_output("busy",     int'(busy),       int'(!model_idle() || mq.size() != 0));
        check_output("overflow", int'(overflow),   int'(m_ovf));
        check_output("spi_send", int'(spi_send),   int'(pop_cyc >= 0 && cyc == pop_cyc + 1));
        check_output("spi_data", int'(spi_data),   int'(m_cur[7:0]));
        check_output("spi_rs",   int'(spi_rs),     int'(m_cur[8]));
    endtask

    // Advance the model by one clock using the inputs driven for the current cycle.
    task automatic model_step();
        bit idle;
        bit dropped;
        idle    = model_idle();
        dropped = 1'b0;
        if (pop_cyc >= 0 && done_cyc < 0 && cyc >= pop_cyc + 3 && spi_done) begin
            done_cyc = cyc;
        end
        if (flush) begin
            mq.delete();
        end else begin
            if (idle && mq.size() > 0) begin
                m_cur    = mq.pop_front();
                pop_cyc  = cyc;
                done_cyc = -1;
            end
            if (wr_en) begin
                if (mq.size() < DEPTH) mq.push_back(wr_data);
                else dropped = 1'b1;
            end
        end
        if (dropped) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        cyc++;
    endtask

    task automatic apply_stimulus(input logic w, input logic [9:0] d, input logic f,
                                  input logic c, input logic dn);
        @(negedge HCLK);
        check_all();
        wr_en    = w;
        wr_data  = d;
        flush    = f;
        clr_ovf  = c;
        spi_done = dn;
        model_step();
    endtask

    task automatic idle_cycles(input int n, input logic dn);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 10'h000, 1'b0, 1'b0, dn);
    endtask

    function logic [9:0] rand_entry();
        logic [9:0] e;
        e      = 10'($urandom);
        e[9]   = 1'b0;
        return e;
    endfunction

    initial begin
        cyc = 0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Single byte from reset, run through its full settle gap
        apply_stimulus(1'b1, 10'h141, 1'b0, 1'b0, 1'b1);
        idle_cycles(70, 1'b1);

        // Burst of eight while the previous byte is still settling
        apply_stimulus(1'b1, 10'h0AA, 1'b0, 1'b0, 1'b1);
        idle_cycles(5, 1'b1);
        for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, rand_entry(), 1'b0, 1'b0, 1'b1);
        idle_cycles(520, 1'b1);

        // Overflow with the SPI engine stalled, then clear racing a dropped push
        apply_stimulus(1'b1, rand_entry(), 1'b0, 1'b0, 1'b0);
        idle_cycles(6, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) apply_stimulus(1'b1, rand_entry(), 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, rand_entry(), 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
        idle_cycles(3, 1'b0);
        idle_cycles(560, 1'b1);

        // Long entry followed by a normal one
        apply_stimulus(1'b1, 10'h201, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b1, 10'h055, 1'b0, 1'b0, 1'b1);
        idle_cycles(120, 1'b1);

        // Flush while the current byte waits on the engine
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, rand_entry(), 1'b0, 1'b0, 1'b0);
        idle_cycles(8, 1'b0);
        apply_stimulus(1'b1, rand_entry(), 1'b1, 1'b0, 1'b0);
        idle_cycles(5, 1'b0);
        idle_cycles(80, 1'b1);

        // Randomized traffic with random engine completion
        for (int i = 0; i < 3000; i++) begin
            logic [9:0] e;
            e = 10'($urandom);
            apply_stimulus(($urandom_range(0, 5) == 0), e, ($urandom_range(0, 199) == 0),
                           ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0));
        end
        idle_cycles(20, 1'b1);
        apply_stimulus(1'b0, 10'h000, 1'b1, 1'b1, 1'b1);
        idle_cycles(80, 1'b1);

        // Asynchronous reset in the middle of a settle gap
        apply_stimulus(1'b1, 10'h133, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b1, 10'h044, 1'b0, 1'b0, 1'b1);
        idle_cycles(10, 1'b1);
        @(posedge HCLK);
        #2;
        HRESETn = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge HCLK);
        wr_en   = 1'b0;
        flush   = 1'b0;
        clr_ovf = 1'b0;
        HRESETn = 1'b1;
        idle_cycles(5, 1'b1);
        apply_stimulus(1'b1, 10'h1C3, 1'b0, 1'b0, 1'b1);
        idle_cycles(60, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
